// File: rtl/sudoku_board_engine.sv
// Sudoku board engine: board and given-mask storage, cursor and entry keys, sequential conflict and solved checks.
// Latency: cursor/grid update 1 cycle after a key; conflict N cycles after the write; solved 3N cycles after that.
// Backpressure: none; keys and loads arriving while busy are dropped without any indication.
module sudoku_board_engine #(
  parameter int BOX   = 3,
  parameter int VAL_W = 4,
  parameter int IDX_W = 4,
  localparam int N    = BOX * BOX
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_clear,
  input  logic                 load_valid,
  input  logic [IDX_W-1:0]     load_row,
  input  logic [IDX_W-1:0]     load_col,
  input  logic [VAL_W-1:0]     load_value,
  input  logic                 load_given,
  input  logic                 key_valid,
  input  logic [2:0]           key_code,
  input  logic [VAL_W-1:0]     user_value,
  output logic [IDX_W-1:0]     cursor_row,
  output logic [IDX_W-1:0]     cursor_col,
  output logic [N*N*VAL_W-1:0] grid_flat,
  output logic [N*N-1:0]       given_flat,
  output logic                 busy,
  output logic                 reject,
  output logic                 conflict,
  output logic                 solved
);

  localparam int FC_W = $clog2(N*N + 1);
  localparam int CW   = $clog2(3*N);

  typedef enum logic [1:0] {IDLE, CHECK, VERIFY} state_t;

  state_t              state;
  logic [N*N*VAL_W-1:0] grid_q;
  logic [N*N-1:0]       given_q;
  logic [FC_W-1:0]      filled;
  logic [CW-1:0]        cnt;
  logic [IDX_W-1:0]     wr_r;
  logic [IDX_W-1:0]     wr_c;
  logic [VAL_W-1:0]     wr_v;
  logic                 hit;
  logic                 all_ok;
  logic                 chk_match;
  logic                 unit_pass;
  logic [N-1:0]         seen;
  logic                 load_ok;
  logic                 cur_given;
  logic [VAL_W-1:0]     cur_val;
  logic [VAL_W-1:0]     load_old;
  int                   cur_idx;
  int                   load_idx;

  function automatic logic [VAL_W-1:0] cell_at(input logic [N*N*VAL_W-1:0] g,
                                               input int r, input int c);
    return g[(r*N + c)*VAL_W +: VAL_W];
  endfunction

  // Occupancy tracking: count only empty<->nonempty transitions, not overwrites
  function automatic logic [FC_W-1:0] fill_next(input logic [FC_W-1:0] f,
                                                input logic [VAL_W-1:0] old_v,
                                                input logic [VAL_W-1:0] new_v);
    if (old_v == '0 && new_v != '0) return f + FC_W'(1);
    if (old_v != '0 && new_v == '0) return f - FC_W'(1);
    return f;
  endfunction

  assign cur_idx    = int'(cursor_row) * N + int'(cursor_col);
  assign cur_val    = cell_at(grid_q, int'(cursor_row), int'(cursor_col));
  assign cur_given  = given_q[cur_idx];
  assign load_ok    = (load_row < IDX_W'(N)) && (load_col < IDX_W'(N));
  assign load_idx   = int'(load_row) * N + int'(load_col);
  assign load_old   = load_ok ? cell_at(grid_q, int'(load_row), int'(load_col)) : '0;
  assign grid_flat  = grid_q;
  assign given_flat = given_q;
  assign busy       = (state != IDLE);

  // One CHECK step: compare the written cell with row, column and box cell k
  always_comb begin
    int k, wr, wc, br, bc;
    k  = int'(cnt);
    wr = int'(wr_r);
    wc = int'(wr_c);
    br = (wr / BOX) * BOX + k / BOX;
    bc = (wc / BOX) * BOX + k % BOX;
    chk_match = 1'b0;
    if (wr_v != '0 && k < N) begin
      if (k != wc && cell_at(grid_q, wr, k) == wr_v) chk_match = 1'b1;
      if (k != wr && cell_at(grid_q, k, wc) == wr_v) chk_match = 1'b1;
      if (!(br == wr && bc == wc) && cell_at(grid_q, br, bc) == wr_v) chk_match = 1'b1;
    end
  end

  // One VERIFY step: one-hot OR of the unit's cells must cover every value 1..N
  always_comb begin
    int u, r, c, v;
    u = int'(cnt);
    r = 0;
    c = 0;
    v = 0;
    seen = '0;
    for (int j = 0; j < N; j++) begin
      if (u < N) begin
        r = u;
        c = j;
      end else if (u < 2*N) begin
        r = j;
        c = u - N;
      end else if (u < 3*N) begin
        r = ((u - 2*N) / BOX) * BOX + j / BOX;
        c = ((u - 2*N) % BOX) * BOX + j % BOX;
      end else begin
        r = 0;
        c = 0;
      end
      v = int'(cell_at(grid_q, r, c));
      if (v >= 1 && v <= N) seen[v-1] = 1'b1;
    end
    unit_pass = &seen;
  end

  // Control FSM with board, cursor and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grid_q     <= '0;
      given_q    <= '0;
      filled     <= '0;
      cnt        <= '0;
      wr_r       <= '0;
      wr_c       <= '0;
      wr_v       <= '0;
      hit        <= 1'b0;
      all_ok     <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
      reject     <= 1'b0;
      conflict   <= 1'b0;
      solved     <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (load_clear) begin
            grid_q   <= '0;
            given_q  <= '0;
            filled   <= '0;
            conflict <= 1'b0;
            solved   <= 1'b0;
          end else if (load_valid) begin
            // a simultaneous key is dropped even when the load itself is out of range
            if (load_ok) begin
              grid_q[load_idx*VAL_W +: VAL_W] <= load_value;
              given_q[load_idx]               <= load_given;
              filled                          <= fill_next(filled, load_old, load_value);
              solved                          <= 1'b0;
            end
          end else if (key_valid) begin
            case (key_code)
              3'd0: cursor_row <= (cursor_row == '0) ? IDX_W'(N-1) : cursor_row - IDX_W'(1);
              3'd1: cursor_row <= (cursor_row == IDX_W'(N-1)) ? '0 : cursor_row + IDX_W'(1);
              3'd2: cursor_col <= (cursor_col == '0) ? IDX_W'(N-1) : cursor_col - IDX_W'(1);
              3'd3: cursor_col <= (cursor_col == IDX_W'(N-1)) ? '0 : cursor_col + IDX_W'(1);
              3'd4, 3'd5: begin
                if (cur_given ||
                    (key_code == 3'd4 && (user_value == '0 || user_value > VAL_W'(N)))) begin
                  reject <= 1'b1;
                end else begin
                  grid_q[cur_idx*VAL_W +: VAL_W] <= (key_code == 3'd4) ? user_value : '0;
                  filled <= fill_next(filled, cur_val, (key_code == 3'd4) ? user_value : '0);
                  wr_r   <= cursor_row;
                  wr_c   <= cursor_col;
                  wr_v   <= (key_code == 3'd4) ? user_value : '0;
                  hit    <= 1'b0;
                  cnt    <= '0;
                  solved <= 1'b0;
                  state  <= CHECK;
                end
              end
              default: ;
            endcase
          end
        end
        CHECK: begin
          hit <= hit | chk_match;
          if (cnt == CW'(N-1)) begin
            conflict <= hit | chk_match;
            cnt      <= '0;
            all_ok   <= 1'b1;
            state    <= (filled == FC_W'(N*N)) ? VERIFY : IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        VERIFY: begin
          all_ok <= all_ok & unit_pass;
          if (cnt == CW'(3*N-1)) begin
            solved <= all_ok & unit_pass;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
